// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg
// Shared constants, types and elaboration-time helpers for the switch /
// push-button debouncer (sw_debounce and its per-channel debounce_ch).
package sw_debounce_pkg;

  // Number of 1 ms ticks per second; the tick divider is CLK_HZ / MS_PER_S.
  localparam int MS_PER_S = 32'sd1000;

  // Decision taken by a channel in one cycle when it evaluates its input.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_kind_e;

  // Clock cycles per 1 ms tick, never less than one cycle.
  function automatic int tick_div(input int clk_hz);
    int div;
    div = clk_hz / MS_PER_S;
    if (div < 32'sd1) begin
      return 32'sd1;
    end else begin
      return div;
    end
  endfunction

  // Width of the tick prescaler counter that spans 0..div-1 (at least 1 bit).
  function automatic int tick_width(input int div);
    int w;
    w = $clog2(div);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

  // Width of a channel's stability counter, $clog2(debounce_ms+1), at least 1 bit.
  function automatic int cnt_width(input int debounce_ms);
    int w;
    w = $clog2(debounce_ms + 32'sd1);
    if (w < 32'sd1) begin
      return 32'sd1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch
// One input channel: optional inversion, 2-FF synchroniser, stability
// counter advanced by the shared 1 ms tick, debounced level and registered
// one-cycle rise/fall pulses. Synchronous active-low reset.
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_MS = 10,
  parameter logic INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_MS);
  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic             s0_r;
  logic             s1_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             rise_r;
  logic             fall_r;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic             level_nxt_s;
  edge_kind_e       edge_s;

  // Bring the asynchronous pin into the clock domain; only s1_r is used below.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_r <= 1'b0;
      s1_r <= 1'b0;
    end else begin
      s0_r <= raw ^ INVERT;
      s1_r <= s0_r;
    end
  end

  // Decide the next count/level: any agreement restarts the count, and only a
  // tick can advance it or accept the new level.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    edge_s      = EDGE_NONE;
    if (s1_r == level_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (tick) begin
      // >= keeps an out-of-range count from stalling the channel.
      if (cnt_r >= CNT_LAST) begin
        cnt_nxt_s   = CNT_ZERO;
        level_nxt_s = s1_r;
        if (s1_r) begin
          edge_s = EDGE_RISE;
        end else begin
          edge_s = EDGE_FALL;
        end
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Register count and level; pulses share the edge that updates the level so
  // they are visible in the same cycle as the new level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
      case (edge_s)
        EDGE_RISE: begin
          rise_r <= 1'b1;
          fall_r <= 1'b0;
        end
        EDGE_FALL: begin
          rise_r <= 1'b0;
          fall_r <= 1'b1;
        end
        default: begin
          rise_r <= 1'b0;
          fall_r <= 1'b0;
        end
      endcase
    end
  end

  assign level = level_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce
// Conditions raw slide-switch / push-button pins for the PIO input port:
// per-channel synchronise + debounce against a shared 1 ms tick, with clean
// levels, one-cycle rise/fall pulses and (optionally) sticky rise flags.
//
// Build option: define SW_DEBOUNCE_EDGE_CAPTURE_EN to enable the EDGE_CAP
// sticky rise flags cleared by CAP_CLR. Without it EDGE_CAP reads 0 and
// CAP_CLR is ignored.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               CLK_HZ      = 50000000,
  parameter int               DEBOUNCE_MS = 10,
  parameter logic [WIDTH-1:0] INVERT      = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN_RAW,
  output logic [WIDTH-1:0] OUT_LEVEL,
  output logic [WIDTH-1:0] OUT_RISE,
  output logic [WIDTH-1:0] OUT_FALL,
  input  logic [WIDTH-1:0] CAP_CLR,
  output logic [WIDTH-1:0] EDGE_CAP
);

  localparam int TICK_DIV = tick_div(CLK_HZ);
  localparam int TICK_W   = tick_width(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 32'sd1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1'b1);

  logic [TICK_W-1:0] tick_cnt_r;
  logic              tick_s;

  logic [WIDTH-1:0]  level_s;
  logic [WIDTH-1:0]  rise_s;
  logic [WIDTH-1:0]  fall_s;

  // With TICK_DIV = 1 the counter sits at 0 == TICK_LAST, so tick is constant 1.
  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Shared 1 ms prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tick_cnt_r <= TICK_ZERO;
    end else if (tick_s) begin
      tick_cnt_r <= TICK_ZERO;
    end else begin
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
    end
  end

  // One independent debouncer per pin.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .INVERT      (INVERT[gi])
    ) u_ch (
      .clk   (CLK),
      .rst_n (RST_N),
      .tick  (tick_s),
      .raw   (IN_RAW[gi]),
      .level (level_s[gi]),
      .rise  (rise_s[gi]),
      .fall  (fall_s[gi])
    );
  end

  assign OUT_LEVEL = level_s;
  assign OUT_RISE  = rise_s;
  assign OUT_FALL  = fall_s;

`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] edge_cap_r;

  // Sticky rise flags; a rise in the same cycle as a clear wins so no press is lost.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      edge_cap_r <= {WIDTH{1'b0}};
    end else begin
      edge_cap_r <= (edge_cap_r & ~CAP_CLR) | rise_s;
    end
  end

  assign EDGE_CAP = edge_cap_r;
`else
  // Feature disabled: the clear input has no function.
  logic cap_clr_unused_s;
  assign cap_clr_unused_s = ^CAP_CLR;
  assign EDGE_CAP         = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
// Directed bench for sw_debounce. Instance a ticks every cycle
// (CLK_HZ=1000, DEBOUNCE_MS=3); instance b ticks every 5 cycles
// (CLK_HZ=5000, DEBOUNCE_MS=3) with all channels inverted.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EDGE_CAPTURE_EN
  localparam logic [3:0] CAP_MASK = 4'hF;
`else
  localparam logic [3:0] CAP_MASK = 4'h0;
`endif

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic [3:0] raw_a, raw_b, clr_a, clr_b;
  logic [3:0] level_a, rise_a, fall_a, cap_a;
  logic [3:0] level_b, rise_b, fall_b, cap_b;

  int n_checks;
  int n_fail;

  sw_debounce #(
    .WIDTH(4), .CLK_HZ(1000), .DEBOUNCE_MS(3), .INVERT(4'h0)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n_a), .IN_RAW(raw_a), .OUT_LEVEL(level_a),
    .OUT_RISE(rise_a), .OUT_FALL(fall_a), .CAP_CLR(clr_a), .EDGE_CAP(cap_a)
  );

  sw_debounce #(
    .WIDTH(4), .CLK_HZ(5000), .DEBOUNCE_MS(3), .INVERT(4'hF)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n_b), .IN_RAW(raw_b), .OUT_LEVEL(level_b),
    .OUT_RISE(rise_b), .OUT_FALL(fall_b), .CAP_CLR(clr_b), .EDGE_CAP(cap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first;
    int cnt;
    logic [3:0] pulses;
    logic [3:0] bpat;

    n_checks = 0;
    n_fail   = 0;
    rst_n_a = 1'b0; raw_a = 4'hF; clr_a = 4'h0;
    rst_n_b = 1'b0; raw_b = 4'hF; clr_b = 4'h0;

    // Reset with all pins high.
    repeat (3) step();
    check_val("rst_level", {28'd0, level_a}, 32'h0);
    check_val("rst_rise",  {28'd0, rise_a},  32'h0);
    check_val("rst_fall",  {28'd0, fall_a},  32'h0);
    check_val("rst_cap",   {28'd0, cap_a},   32'h0);

    // Release: 2 sync + 3 ticks -> level visible after the 5th edge.
    rst_n_a = 1'b1;
    repeat (4) step();
    check_val("rel_level_early", {28'd0, level_a}, 32'h0);
    step();
    check_val("rel_level", {28'd0, level_a}, 32'hF);
    check_val("rel_rise",  {28'd0, rise_a},  32'hF);
    check_val("rel_fall",  {28'd0, fall_a},  32'h0);
    step();
    check_val("rel_rise_end", {28'd0, rise_a}, 32'h0);
    check_val("rel_cap",      {28'd0, cap_a},  {28'd0, 4'hF & CAP_MASK});

    // All pins fall together.
    raw_a = 4'h0;
    repeat (4) step();
    check_val("fall_level_early", {28'd0, level_a}, 32'hF);
    step();
    check_val("fall_level", {28'd0, level_a}, 32'h0);
    check_val("fall_pulse", {28'd0, fall_a},  32'hF);
    check_val("fall_rise",  {28'd0, rise_a},  32'h0);
    step();
    check_val("fall_pulse_end", {28'd0, fall_a}, 32'h0);

    // Clean step on bit 0: rise on the 5th edge only.
    raw_a = 4'b0001;
    first = 0; cnt = 0; pulses = 4'h0;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (rise_a[0]) begin
        cnt++;
        if (first == 0) first = j;
      end
      pulses = pulses | fall_a | (rise_a & 4'b1110);
    end
    check_val("step_rise_at", first, 32'd5);
    check_val("step_rise_cnt", cnt, 32'd1);
    check_val("step_other_pulses", {28'd0, pulses}, 32'h0);
    check_val("step_level", {28'd0, level_a}, 32'h1);

    // Bounce on bit 1: 1,0,1,0 then steady 1 from cycle 4 -> rise at edge 9.
    bpat = 4'b0101;
    first = 0; cnt = 0; pulses = 4'h0;
    for (int j = 0; j < 14; j++) begin
      if (j < 4) raw_a[1] = bpat[j];
      else       raw_a[1] = 1'b1;
      step();
      if (rise_a[1]) begin
        cnt++;
        if (first == 0) first = j + 1;
      end
      pulses = pulses | fall_a;
    end
    check_val("bounce_rise_at", first, 32'd9);
    check_val("bounce_rise_cnt", cnt, 32'd1);
    check_val("bounce_no_fall", {28'd0, pulses}, 32'h0);
    check_val("bounce_level", {28'd0, level_a}, 32'h3);

    // Two-cycle glitch on bit 2 is rejected.
    pulses = 4'h0;
    for (int j = 0; j < 12; j++) begin
      raw_a[2] = (j < 2) ? 1'b1 : 1'b0;
      step();
      pulses = pulses | rise_a | fall_a;
    end
    check_val("glitch_pulses", {28'd0, pulses}, 32'h0);
    check_val("glitch_level", {28'd0, level_a}, 32'h3);

    // Clear all capture flags.
    clr_a = 4'hF;
    step();
    check_val("cap_clear_all", {28'd0, cap_a}, 32'h0);
    clr_a = 4'h0;

    // Rise on bit 2 while CAP_CLR[2] is held: set wins, then clear next cycle.
    raw_a[2] = 1'b1;
    repeat (4) step();
    clr_a[2] = 1'b1;
    step();
    check_val("cap_rise2", {28'd0, rise_a}, 32'h4);
    check_val("cap_before_set", {28'd0, cap_a}, 32'h0);
    step();
    check_val("cap_set_priority", {28'd0, cap_a}, {28'd0, 4'h4 & CAP_MASK});
    step();
    check_val("cap_cleared", {28'd0, cap_a}, 32'h0);
    clr_a = 4'h0;

    // Instance b: inverted pins held high read as logical 0.
    rst_n_b = 1'b1;
    pulses = 4'h0;
    for (int j = 0; j < 7; j++) begin
      step();
      pulses = pulses | rise_b | fall_b;
    end
    check_val("inv_hold_pulses", {28'd0, pulses}, 32'h0);
    check_val("inv_hold_level", {28'd0, level_b}, 32'h0);

    // Release key 3 (pin low = pressed) at edge 7; ticks on edges 10,15,20.
    raw_b = 4'b0111;
    first = 0;
    for (int j = 1; j <= 15; j++) begin
      step();
      if (rise_b[3] && first == 0) first = j;
    end
    check_val("div_rise_at", first, 32'd13);
    check_val("div_rise_level", {28'd0, level_b}, 32'h8);
    check_val("div_cap", {28'd0, cap_b}, {28'd0, 4'h8 & CAP_MASK});

    // Pin back high at edge 22; ticks on 25,30,35 -> fall 13 edges later.
    raw_b = 4'hF;
    first = 0;
    for (int j = 1; j <= 15; j++) begin
      step();
      if (fall_b[3] && first == 0) first = j;
    end
    check_val("div_fall_at", first, 32'd13);
    check_val("div_fall_level", {28'd0, level_b}, 32'h0);

    // Press again, then reset mid-count: partial count must be discarded.
    raw_b = 4'b0111;
    pulses = 4'h0;
    repeat (6) begin
      step();
      pulses = pulses | rise_b;
    end
    rst_n_b = 1'b0;
    repeat (3) begin
      step();
      pulses = pulses | rise_b | fall_b;
    end
    check_val("midrst_no_pulse", {28'd0, pulses}, 32'h0);
    check_val("midrst_level", {28'd0, level_b}, 32'h0);
    rst_n_b = 1'b1;
    first = 0; cnt = 0;
    for (int j = 1; j <= 18; j++) begin
      step();
      if (rise_b[3]) begin
        cnt++;
        if (first == 0) first = j;
      end
    end
    check_val("midrst_fresh_rise_at", first, 32'd15);
    check_val("midrst_fresh_rise_cnt", cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
